// File: rtl/const_mon_pkg.sv
// Shared types for the constant-bit bus monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: monitor state enum, result record (mask, value, window id),
// monitored-bus width and window-id width constants.
package const_mon_pkg;

    // Width of the monitored result bus; the result record is sized from it.
    localparam int MON_WIDTH = 16;

    // Window index width; the index wraps 255 -> 0.
    localparam int WIN_ID_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [MON_WIDTH-1:0] mask;   // 1 = bit never toggled in the window
        logic [MON_WIDTH-1:0] value;  // level of the constant bits, 0 elsewhere
        logic [WIN_ID_W-1:0]  id;     // window index
    } res_t;

endpackage : const_mon_pkg

// File: rtl/const_bus_monitor_if.sv
// Sample and result bundle between the observed datapath and the monitor.
// Latency: n/a (wiring only).
// Backpressure: res_ready from the consumer stalls the result port.
//
// master: drives samples and res_ready, receives results (datapath/consumer side).
// slave : receives samples and res_ready, drives results (the monitor).
interface const_bus_monitor_if
    import const_mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH
);
    logic                sample_en;
    logic [WIDTH-1:0]    bus_in;
    logic                res_valid;
    logic                res_ready;
    logic [WIDTH-1:0]    res_const_mask;
    logic [WIDTH-1:0]    res_const_value;
    logic [WIN_ID_W-1:0] res_window_id;

    modport master (
        output sample_en, bus_in, res_ready,
        input  res_valid, res_const_mask, res_const_value, res_window_id
    );

    modport slave (
        input  sample_en, bus_in, res_ready,
        output res_valid, res_const_mask, res_const_value, res_window_id
    );
endinterface : const_bus_monitor_if

// File: rtl/const_mon_outbuf.sv
// One-entry valid/ready result buffer with drop indication.
// Latency: a loaded entry is visible (out_vld=1) the cycle after load_vld.
// Backpressure: a load while full and not draining is dropped (load_drop=1); held entry stays put.
//
// Ports: clock, reset_n; load_vld/load_dat (offer), out_vld/out_rdy/out_dat
// (consumer side), load_drop (pulse, offer was refused).
module const_mon_outbuf #(
    parameter type dat_t = logic
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_vld,
    input  dat_t load_dat,
    output logic out_vld,
    input  logic out_rdy,
    output dat_t out_dat,
    output logic load_drop
);
    logic load_ok;

    // Room exists when empty or when the held entry leaves this same cycle.
    // out_vld is a pure register, so it never depends on out_rdy combinationally.
    assign load_ok   = !out_vld || out_rdy;
    assign load_drop = load_vld && !load_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load_vld && load_ok) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end
endmodule : const_mon_outbuf

// File: rtl/const_bus_monitor.sv
// Constant-bit monitor: per window of WINDOW accepted samples, reports which bus bits never toggled.
// Latency: result valid the cycle after the completing sample.
// Backpressure: one-entry result buffer; a window completing while it is full is dropped and overflow set.
//
// Ports: clock, reset_n (async, active low); start/stop pulses (stop wins);
// bus (slave modport: sample_en, bus_in, res_* result port); overflow (sticky);
// busy (state is RUN); drop_count (only with CONST_MON_DROP_CNT_EN defined,
// saturating count of dropped windows).
module const_bus_monitor
    import const_mon_pkg::*;
#(
    parameter int WIDTH  = MON_WIDTH,   // must equal MON_WIDTH (result record size)
    parameter int WINDOW = 8            // 2..255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    const_bus_monitor_if.slave  bus,
    output logic                overflow,
    output logic                busy
`ifdef CONST_MON_DROP_CNT_EN
    ,
    output logic [7:0]          drop_count
`endif
);
    localparam logic [7:0] WINDOW_C = 8'(WINDOW);

    state_t state, state_nxt;

    logic [WIDTH-1:0]    seen0, seen1;
    logic [WIDTH-1:0]    seen0_upd, seen1_upd;
    logic [7:0]          count, count_inc;
    logic [WIN_ID_W-1:0] win_id;

    logic start_acc;   // start that is not overridden by stop
    logic smp_acc;     // sample that enters the current window
    logic win_done;    // sample that completes the window
    logic res_drop;
    logic res_vld;
    res_t res_new, res_q;

    assign start_acc = start && !stop;

    // A start/stop in the same cycle as a sample discards it, which also
    // discards any window that sample would have completed.
    assign smp_acc   = (state == RUN) && bus.sample_en && !start && !stop;
    assign count_inc = count + 8'd1;
    assign win_done  = smp_acc && (count_inc == WINDOW_C);

    assign seen0_upd = seen0 | ~bus.bus_in;
    assign seen1_upd = seen1 |  bus.bus_in;

    // A bit is constant unless it was seen at both levels.
    always_comb begin
        res_new       = '0;
        res_new.mask  = ~(seen0_upd & seen1_upd);
        res_new.value = seen1_upd & res_new.mask;
        res_new.id    = win_id;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
    end

    assign busy = (state == RUN);

    // ---------------- Accumulators ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen0 <= '0;
            seen1 <= '0;
            count <= '0;
        end else if (start_acc || stop || win_done) begin
            seen0 <= '0;
            seen1 <= '0;
            count <= '0;
        end else if (smp_acc) begin
            seen0 <= seen0_upd;
            seen1 <= seen1_upd;
            count <= count_inc;
        end
    end

    // Window index advances on every completed window, kept or dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       win_id <= '0;
        else if (start_acc) win_id <= '0;
        else if (win_done)  win_id <= win_id + 8'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       overflow <= 1'b0;
        else if (start_acc) overflow <= 1'b0;
        else if (res_drop)  overflow <= 1'b1;
    end

`ifdef CONST_MON_DROP_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          drop_count <= '0;
        else if (start_acc)                    drop_count <= '0;
        else if (res_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
`endif

    // ---------------- Result buffer ----------------
    const_mon_outbuf #(.dat_t(res_t)) u_outbuf (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_vld  (win_done),
        .load_dat  (res_new),
        .out_vld   (res_vld),
        .out_rdy   (bus.res_ready),
        .out_dat   (res_q),
        .load_drop (res_drop)
    );

    assign bus.res_valid       = res_vld;
    assign bus.res_const_mask  = res_q.mask;
    assign bus.res_const_value = res_q.value;
    assign bus.res_window_id   = res_q.id;

endmodule : const_bus_monitor
